// File: rtl/tri_pkg.sv
// Shared constants for the triangle feeder: coordinate width, FSM encoding
// and vertex field positions inside a packed triangle word.
package tri_pkg;

  localparam int COORD_W = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_S1    = 3'd1;
  localparam logic [2:0] ST_S2    = 3'd2;
  localparam logic [2:0] ST_S3    = 3'd3;
  localparam logic [2:0] ST_WAITB = 3'd4;
  localparam logic [2:0] ST_SCAN  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;
  localparam logic [2:0] ST_TOUT  = 3'd7;

  // Field positions in units of the coordinate width; x1 occupies the MSBs.
  localparam int X1_FLD = 5;
  localparam int Y1_FLD = 4;
  localparam int X2_FLD = 3;
  localparam int Y2_FLD = 2;
  localparam int X3_FLD = 1;
  localparam int Y3_FLD = 0;

endpackage

// File: rtl/tri_fifo.sv
// Generic synchronous FIFO with a combinational head; holds queued triangles
// until the feeder has finished (or dropped) them.
module tri_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rd_data   = mem_r[rd_ptr_r];

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/tri_feeder.sv
// Host-side feeder for the triangle rasterizer: queues triangles, issues the
// three vertices, then gathers the covered-pixel stream into a bitmap.
module tri_feeder
  import tri_pkg::*;
#(
  parameter int W     = COORD_W,
  parameter int DEPTH = 4,
  parameter int TMO   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tv_valid,
  output logic                  tv_ready,
  input  logic [6*W-1:0]        tv_data,
  output logic                  nt,
  output logic [W-1:0]          xi,
  output logic [W-1:0]          yi,
  input  logic                  busy,
  input  logic                  po,
  input  logic [W-1:0]          xo,
  input  logic [W-1:0]          yo,
  output logic                  done,
  output logic                  err,
  output logic [2*W:0]          pix_cnt,
  output logic [(1<<(2*W))-1:0] bitmap
);
  localparam int TW = $clog2(TMO + 1);
  localparam int CW = 2*W + 1;

  logic [2:0]               state_r;
  logic [2:0]               state_n;
  logic                     nt_r;
  logic [W-1:0]             xi_r;
  logic [W-1:0]             yi_r;
  logic                     done_r;
  logic                     err_r;
  logic [TW-1:0]            tmo_cnt_r;
  logic [CW-1:0]            pix_cnt_r;
  logic [(1<<(2*W))-1:0]    bitmap_r;
  logic [6*W-1:0]           head_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     hit_s;
  logic [W-1:0]             vx_s;
  logic [W-1:0]             vy_s;

  assign tv_ready = !fifo_full_s;
  assign push_s   = tv_valid && !fifo_full_s;
  assign pop_s    = (state_r == ST_DONE) || (state_r == ST_TOUT);
  // the first busy cycle seen in WAITB already counts as a scan cycle
  assign hit_s    = ((state_r == ST_WAITB) || (state_r == ST_SCAN)) && busy && po;

  assign nt      = nt_r;
  assign xi      = xi_r;
  assign yi      = yi_r;
  assign done    = done_r;
  assign err     = err_r;
  assign pix_cnt = pix_cnt_r;
  assign bitmap  = bitmap_r;

  tri_fifo #(
    .DEPTH (DEPTH),
    .DW    (6*W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (tv_data),
    .rd_data (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) state_n = ST_S1;
        else               state_n = ST_IDLE;
      end
      ST_S1:   state_n = ST_S2;
      ST_S2:   state_n = ST_S3;
      ST_S3:   state_n = ST_WAITB;
      ST_WAITB: begin
        if (busy)                              state_n = ST_SCAN;
        else if (tmo_cnt_r == TW'(TMO - 1))    state_n = ST_TOUT;
        else                                   state_n = ST_WAITB;
      end
      ST_SCAN: begin
        if (!busy) state_n = ST_DONE;
        else       state_n = ST_SCAN;
      end
      ST_DONE: state_n = ST_IDLE;
      ST_TOUT: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // vertex selected for the upcoming state; registered so xi/yi track it
  always_comb begin
    vx_s = xi_r;
    vy_s = yi_r;
    case (state_n)
      ST_S1: begin
        vx_s = head_s[X1_FLD*W +: W];
        vy_s = head_s[Y1_FLD*W +: W];
      end
      ST_S2: begin
        vx_s = head_s[X2_FLD*W +: W];
        vy_s = head_s[Y2_FLD*W +: W];
      end
      ST_S3: begin
        vx_s = head_s[X3_FLD*W +: W];
        vy_s = head_s[Y3_FLD*W +: W];
      end
      default: begin
        vx_s = xi_r;
        vy_s = yi_r;
      end
    endcase
  end

  // state, strobes, timeout counter and coverage capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      nt_r      <= 1'b0;
      xi_r      <= '0;
      yi_r      <= '0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      tmo_cnt_r <= '0;
      pix_cnt_r <= '0;
      bitmap_r  <= '0;
    end else begin
      state_r <= state_n;
      nt_r    <= (state_n == ST_S1);
      xi_r    <= vx_s;
      yi_r    <= vy_s;
      done_r  <= (state_n == ST_DONE);
      err_r   <= (state_n == ST_TOUT);
      if (state_r == ST_S3) begin
        tmo_cnt_r <= '0;
      end else if ((state_r == ST_WAITB) && !busy) begin
        tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end
      // cleared on entry so the S1 cycle already shows an empty bitmap
      if (state_n == ST_S1) begin
        pix_cnt_r <= '0;
        bitmap_r  <= '0;
      end else if (hit_s) begin
        pix_cnt_r          <= pix_cnt_r + CW'(1);
        bitmap_r[{yo, xo}] <= 1'b1;
      end
    end
  end

endmodule
